mux_rr_scheduler: RTL
=====================

// Module: mux_rr_scheduler
//
// PURPOSE
//   Round-robin scheduler that shares one 16:1 mux between 16 requesting lanes.
//   - Picks one requester, drives the mux select code and one-hot grant.
//   - Waits one settle cycle, then registers the mux output with its lane index.
//   - Hands the result to a downstream consumer over a valid/ready handshake.
//   - Sits between the accelerator's lane requesters and the shared MuxX16 datapath.
//
// PARAMETERS
//   N_REQ   16  number of requesters / mux inputs (fixed at 16 for MuxX16)
//   SEL_W   4   select width, log2(N_REQ)
//
// PORTS
//   clk         in   1      rising-edge clock
//   rst_n       in   1      asynchronous, active-low reset
//   en          in   1      arbitration enable; gates new grants only
//   req         in   16     request per lane, level-sensitive
//   mux_out     in   1      output of the shared 16:1 mux
//   sel         out  4      mux select code (registered)
//   sel_valid   out  1      sel/grant are driving the mux this cycle
//   grant       out  16     one-hot grant, bit = granted lane
//   data_out    out  1      captured mux output
//   data_idx    out  4      lane index of data_out (always natural order)
//   data_valid  out  1      data_out/data_idx valid
//   data_ready  in   1      downstream accepts when data_valid && data_ready
//   busy        out  1      state != IDLE
//
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, rr_ptr=0, sel=0, grant=0, sel_valid=0,
//     data_out=0, data_idx=0, data_valid=0, busy=0. Takes effect mid-transaction;
//     any in-flight sample is discarded.
//   Arbitration: winner = first asserted req at or after rr_ptr, searching upward
//     with wrap 15->0. After each accepted handshake, rr_ptr = winner+1 (mod 16).
//   FSM:
//     IDLE    : if en && |req -> latch winner into grant/sel, go SELECT.
//     SELECT  : sel_valid=1 for exactly one settle cycle. At its end, register
//               mux_out->data_out and winner->data_idx, data_valid<=1, go OUTPUT.
//     OUTPUT  : data_valid=1; data_out, data_idx, sel and grant held stable.
//               sel_valid=1 (mux kept selected). On data_ready:
//               - rr_ptr updates.
//               - if en && |req: re-arbitrate with the NEW rr_ptr, go SELECT
//                 (back-to-back, no IDLE cycle).
//               - else data_valid<=0, sel_valid<=0, grant<=0, go IDLE.
//   Latency: req high in IDLE at cycle 0 -> sel/grant valid cycle 1 ->
//     data_valid cycle 2. Peak throughput 1 sample / 2 cycles.
//   Grant latched: a req dropping after grant does not abort the transaction.
//   en low mid-transaction: current sample completes; no new grant is issued.
//   No requests: remain IDLE; rr_ptr unchanged.
//   data_ready while !data_valid: ignored.
//
// CONFIGURATION
//   SEL_BITREV_EN defined: sel output is bit-reversed ({sel[0],sel[1],sel[2],sel[3]})
//     to match MuxX16's decode, which treats c[3] as LSB.
//   SEL_BITREV_EN undefined: sel = granted lane index in natural binary.
//   In both cases grant, data_idx and rr_ptr use the natural index.
//
// TESTING
//   1 req=16'h0020, en=1 -> cycle1 grant=16'h0020, sel=5; cycle2 data_valid=1,
//     data_idx=5, data_out = mux_out value sampled in cycle 1.
//   2 req=16'hFFFF held, data_ready=1 -> data_idx sequence 0,1,2,...,15,0.
//     Exactly 2 cycles per sample.
//   3 data_ready=0 for 3 cycles in OUTPUT -> data_out, data_idx, sel and grant
//     stable. Sample accepted on the 4th cycle.
//   4 req=16'h0081, rr_ptr=1 -> grant lane 7 first, then lane 0.
//     Drop req[7] in SELECT -> lane 7 sample still delivered.
//   5 rst_n pulsed low during SELECT -> all outputs 0 immediately.
//     Next grant starts from lane 0.
//   6 With SEL_BITREV_EN, req=16'h0002 -> sel=4'b1000, data_idx=1.
//     Without SEL_BITREV_EN -> sel=4'b0001.

Source files
------------

// File: rtl/mux_rr_scheduler_if.sv
// ---------------------------------------------------------------------------
// mux_rr_scheduler_if
//   Bundles the lane request side, the shared-mux control/return side and the
//   downstream valid/ready result side of the round-robin mux scheduler.
//
//   Signals
//     en          arbitration enable (gates new grants only)
//     req[15:0]   level-sensitive request per lane
//     mux_out     output of the shared 16:1 mux
//     sel[3:0]    mux select code
//     sel_valid   sel/grant currently drive the mux
//     grant[15:0] one-hot grant
//     data_out    captured mux output
//     data_idx    natural lane index of data_out
//     data_valid  data_out/data_idx valid
//     data_ready  downstream accept
//     busy        scheduler not idle
//
//   Modports
//     master : environment side (drives requests, mux return, ready)
//     slave  : scheduler side
// ---------------------------------------------------------------------------
interface mux_rr_scheduler_if;
   logic        en;
   logic [15:0] req;
   logic        mux_out;
   logic [3:0]  sel;
   logic        sel_valid;
   logic [15:0] grant;
   logic        data_out;
   logic [3:0]  data_idx;
   logic        data_valid;
   logic        data_ready;
   logic        busy;

   modport master (
      output en, req, mux_out, data_ready,
      input  sel, sel_valid, grant, data_out, data_idx, data_valid, busy
   );

   modport slave (
      input  en, req, mux_out, data_ready,
      output sel, sel_valid, grant, data_out, data_idx, data_valid, busy
   );
endinterface

// File: rtl/mux_rr_scheduler.sv
// ---------------------------------------------------------------------------
// mux_rr_scheduler
//   Round-robin scheduler sharing one 16:1 mux (MuxX16) among 16 lanes.
//   A winner is granted and selected, the mux is given one settle cycle, then
//   its output is registered together with the lane index and offered to a
//   downstream consumer over valid/ready. Back-to-back grants reach one sample
//   every two cycles.
//
//   Ports
//     clk    : rising-edge clock
//     rst_n  : asynchronous active-low reset
//     bus    : mux_rr_scheduler_if.slave (see interface file for signals)
//
//   Configuration
//     SEL_BITREV_EN : when defined, sel is presented bit-reversed because the
//                     MuxX16 decode treats c[3] as its LSB. grant, data_idx and
//                     the round-robin pointer always use the natural index.
//
//   State   | meaning
//   --------+-------------------------------------------------------------
//   IDLE    | no transaction; waiting for en && |req
//   SELECT  | winner driven onto the mux; one settle cycle
//   OUTPUT  | sample registered and offered; mux kept selected until ready
// ---------------------------------------------------------------------------
module mux_rr_scheduler (
   input  logic                clk,
   input  logic                rst_n,
   mux_rr_scheduler_if.slave   bus
);

   localparam int N_REQ = 16;
   localparam int SEL_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SELECT = 2'd1,
      ST_OUTPUT = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;

   logic [SEL_W-1:0]    r_rr_ptr;
   logic [SEL_W-1:0]    r_idx;
   logic [N_REQ-1:0]    r_grant;
   logic                r_sel_valid;
   logic                r_data_out;
   logic [SEL_W-1:0]    r_data_idx;
   logic                r_data_valid;

   logic [SEL_W-1:0]    w_rr_ptr_nxt;
   logic [SEL_W-1:0]    w_idx_nxt;
   logic [N_REQ-1:0]    w_grant_nxt;
   logic                w_sel_valid_nxt;
   logic                w_data_out_nxt;
   logic [SEL_W-1:0]    w_data_idx_nxt;
   logic                w_data_valid_nxt;

   logic                w_accept;
   logic [SEL_W-1:0]    w_arb_ptr;
   logic [SEL_W-1:0]    w_win_idx;
   logic                w_win_hit;
   logic [N_REQ-1:0]    w_win_onehot;
   logic                w_new_grant;

   // ------------------------------------------------------------------
   // Arbitration
   // ------------------------------------------------------------------
   assign w_accept = (r_state == ST_OUTPUT) && bus.data_ready;

   // On a back-to-back handoff the search must already start from the
   // pointer this handshake is about to write, not the stale one.
   assign w_arb_ptr = w_accept ? (r_idx + SEL_W'(1)) : r_rr_ptr;

   // Scan offsets from highest to lowest so the smallest offset from the
   // pointer (the first requester at or after it) is the final assignment.
   always_comb begin
      logic [SEL_W-1:0] v_cand;
      w_win_idx = '0;
      w_win_hit = 1'b0;
      v_cand    = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         v_cand = w_arb_ptr + SEL_W'(i);
         if (bus.req[v_cand]) begin
            w_win_idx = v_cand;
            w_win_hit = 1'b1;
         end
      end
   end

   assign w_win_onehot = N_REQ'(1) << w_win_idx;
   assign w_new_grant  = bus.en && w_win_hit &&
                         ((r_state == ST_IDLE) || w_accept);

   // ------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_new_grant) begin
               w_state_nxt = ST_SELECT;
            end
         end
         ST_SELECT: begin
            w_state_nxt = ST_OUTPUT;
         end
         ST_OUTPUT: begin
            if (w_accept) begin
               w_state_nxt = w_new_grant ? ST_SELECT : ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // FSM: output logic (next values of the registered outputs)
   // ------------------------------------------------------------------
   always_comb begin
      w_rr_ptr_nxt     = r_rr_ptr;
      w_idx_nxt        = r_idx;
      w_grant_nxt      = r_grant;
      w_sel_valid_nxt  = r_sel_valid;
      w_data_out_nxt   = r_data_out;
      w_data_idx_nxt   = r_data_idx;
      w_data_valid_nxt = r_data_valid;
      case (r_state)
         ST_IDLE: begin
            if (w_new_grant) begin
               w_idx_nxt       = w_win_idx;
               w_grant_nxt     = w_win_onehot;
               w_sel_valid_nxt = 1'b1;
            end
         end
         ST_SELECT: begin
            // End of the settle cycle: the mux output is now trustworthy.
            w_data_out_nxt   = bus.mux_out;
            w_data_idx_nxt   = r_idx;
            w_data_valid_nxt = 1'b1;
         end
         ST_OUTPUT: begin
            if (w_accept) begin
               w_rr_ptr_nxt     = r_idx + SEL_W'(1);
               w_data_valid_nxt = 1'b0;
               if (w_new_grant) begin
                  w_idx_nxt       = w_win_idx;
                  w_grant_nxt     = w_win_onehot;
                  w_sel_valid_nxt = 1'b1;
               end else begin
                  w_grant_nxt     = '0;
                  w_sel_valid_nxt = 1'b0;
               end
            end
         end
         default: begin
            w_grant_nxt      = '0;
            w_sel_valid_nxt  = 1'b0;
            w_data_valid_nxt = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rr_ptr     <= '0;
         r_idx        <= '0;
         r_grant      <= '0;
         r_sel_valid  <= 1'b0;
         r_data_out   <= 1'b0;
         r_data_idx   <= '0;
         r_data_valid <= 1'b0;
      end else begin
         r_rr_ptr     <= w_rr_ptr_nxt;
         r_idx        <= w_idx_nxt;
         r_grant      <= w_grant_nxt;
         r_sel_valid  <= w_sel_valid_nxt;
         r_data_out   <= w_data_out_nxt;
         r_data_idx   <= w_data_idx_nxt;
         r_data_valid <= w_data_valid_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
`ifdef SEL_BITREV_EN
   assign bus.sel = {r_idx[0], r_idx[1], r_idx[2], r_idx[3]};
`else
   assign bus.sel = r_idx;
`endif

   assign bus.sel_valid  = r_sel_valid;
   assign bus.grant      = r_grant;
   assign bus.data_out   = r_data_out;
   assign bus.data_idx   = r_data_idx;
   assign bus.data_valid = r_data_valid;
   assign bus.busy       = (r_state != ST_IDLE);

endmodule
